// File: rtl/lsb_modexp_param_if.sv
// Operand/result bundle for the LSB-first modular exponentiation engine.
// The master side requests work and the slave side (the engine) returns results.
interface lsb_modexp_param_if #(
  parameter int W = 256,
  localparam int CW = $clog2(W) + 1
) ();
  logic          start;
  logic          abort;
  logic [W-1:0]  M_i;
  logic [W-1:0]  N_i;
  logic [W-1:0]  d_i;
  logic [CW-1:0] d_len_i;
  logic          ready;
  logic          done;
  logic          err;
  logic [W-1:0]  S_out;

  modport master (
    output start, abort, M_i, N_i, d_i, d_len_i,
    input  ready, done, err, S_out
  );

  modport slave (
    input  start, abort, M_i, N_i, d_i, d_len_i,
    output ready, done, err, S_out
  );
endinterface

// File: rtl/lsb_modexp_param.sv
// Right-to-left binary modular exponentiation S = M^d mod N. Each exponent bit
// costs W+1 cycles: W cycles of two parallel radix-2 interleaved multipliers, then one update cycle.
module lsb_modexp_param #(
  parameter int W = 256,
  localparam int CW = $clog2(W) + 1
) (
  input logic               clk,
  input logic               reset,
  lsb_modexp_param_if.slave bus
);
  localparam int            JW      = $clog2(W);
  localparam logic [JW-1:0] J_MAX   = JW'(W - 1);
  localparam logic [CW-1:0] LEN_MAX = CW'(W);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, UPD, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  m_q, n_q, d_q, s_q, t_q, ps_q, pt_q, s_out_q;
  logic [CW-1:0] len_q, i_q;
  logic [JW-1:0] j_q;
  logic          ready_q, done_q, err_q;
  logic [W-1:0]  ps_d, pt_d;
  logic          t_bit;

  // One interleaved step: 2P + a*B stays below 3N, so two conditional subtracts suffice.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] p, input logic a_bit,
                                           input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W+1:0] acc;
    logic [W+1:0] nn;
    nn  = {2'b00, n};
    acc = {1'b0, p, 1'b0} + (a_bit ? {2'b00, b} : '0);
    if (acc >= nn) acc = acc - nn;
    if (acc >= nn) acc = acc - nn;
    return acc[W-1:0];
  endfunction

  // Both products scan T from its MSB: Ps = T*S, Pt = T*T.
  assign t_bit = t_q[j_q];
  assign ps_d  = mm_step(ps_q, t_bit, s_q, n_q);
  assign pt_d  = mm_step(pt_q, t_bit, t_q, n_q);

  // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      s_out_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      d_q     <= '0;
      len_q   <= '0;
      s_q     <= '0;
      t_q     <= '0;
      ps_q    <= '0;
      pt_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else if (bus.abort && (state_q inside {LOAD, MUL, UPD})) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      s_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q     <= bus.M_i;
            n_q     <= bus.N_i;
            d_q     <= bus.d_i;
            len_q   <= (bus.d_len_i > LEN_MAX) ? LEN_MAX : bus.d_len_i;
            err_q   <= 1'b0;
            s_out_q <= '0;
            ready_q <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (n_q == '0 || m_q >= n_q) begin
            err_q   <= 1'b1;
            s_out_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (len_q == '0) begin
            s_out_q <= (n_q == W'(1)) ? '0 : W'(1);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            s_q     <= (n_q == W'(1)) ? '0 : W'(1);
            t_q     <= m_q;
            ps_q    <= '0;
            pt_q    <= '0;
            i_q     <= '0;
            j_q     <= J_MAX;
            state_q <= MUL;
          end
        end
        MUL: begin
          ps_q <= ps_d;
          pt_q <= pt_d;
          if (j_q == '0) state_q <= UPD;
          else           j_q     <= j_q - JW'(1);
        end
        UPD: begin
          t_q <= pt_q;
          if (d_q[0]) s_q <= ps_q;
          d_q <= d_q >> 1;
          i_q <= i_q + CW'(1);
          if (i_q + CW'(1) == len_q) begin
            // Publish the final S now so it is valid in the done cycle.
            s_out_q <= d_q[0] ? ps_q : s_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            ps_q    <= '0;
            pt_q    <= '0;
            j_q     <= J_MAX;
            state_q <= MUL;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.S_out = s_out_q;
endmodule

// File: tb/tb_lsb_modexp_param.sv
// Directed and randomized checks of lsb_modexp_param (W=16) against a plain
// square-and-multiply reference model.
module tb_lsb_modexp_param;
  localparam int W  = 16;
  localparam int CW = $clog2(W) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsb_modexp_param_if #(.W(W)) bus ();
  lsb_modexp_param #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass   = 0;
  int n_total  = 0;
  int edge_cnt = 0;
  int t0       = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int eff_len(input int len);
    return (len > W) ? W : len;
  endfunction

  function automatic logic [63:0] model_res(input logic [63:0] m, input logic [63:0] n,
                                            input logic [63:0] d, input int len);
    logic [63:0] r;
    logic [63:0] b;
    if (n == 0 || m >= n) return 0;
    r = 1 % n;
    b = m;
    for (int k = 0; k < eff_len(len); k++) begin
      if (d[k]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [63:0] m, input logic [63:0] n, input int len);
    if (n == 0 || m >= n || eff_len(len) == 0) return 1;
    return 1 + eff_len(len) * (W + 1);
  endfunction

  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] n,
                          input logic [W-1:0] d, input int len);
    bus.M_i     = m;
    bus.N_i     = n;
    bus.d_i     = d;
    bus.d_len_i = CW'(len);
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
    t0          = edge_cnt;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] n,
                           input logic [W-1:0] d, input int len);
    bit seen;
    wait_done(seen);
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(edge_cnt - t0), 64'(model_lat(m, n, len)));
    check({tag, " S_out"}, 64'(bus.S_out), model_res(m, n, d, len));
    check({tag, " err"}, 64'(bus.err), 64'((n == 0 || m >= n) ? 1 : 0));
    cyc();
    check({tag, " ready_after"}, 64'(bus.ready), 64'd1);
    check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run(input string tag, input logic [W-1:0] m, input logic [W-1:0] n,
                     input logic [W-1:0] d, input int len);
    start_op(m, n, d, len);
    finish_op(tag, m, n, d, len);
  endtask

  task automatic watch_no_done(input string tag);
    int hits;
    hits = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (bus.done) hits++;
    end
    check({tag, " no_done"}, 64'(hits), 64'd0);
  endtask

  initial begin
    logic [W-1:0] rm, rn, rd;
    int           rl;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.M_i     = '0;
    bus.N_i     = '0;
    bus.d_i     = '0;
    bus.d_len_i = '0;
    cyc();
    cyc();
    reset = 1'b0;
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset err", 64'(bus.err), 64'd0);
    check("reset S_out", 64'(bus.S_out), 64'd0);

    // Main function, including clamp of oversize length.
    run("5^11 mod 13", 16'd5, 16'd13, 16'b00001011, 4);
    run("4^13 mod 497", 16'd4, 16'd497, 16'd13, 4);
    run("4^13 mod 497 len20", 16'd4, 16'd497, 16'd13, 20);

    // Operand errors, then a valid start clears err in its LOAD cycle.
    run("N=0", 16'd3, 16'd0, 16'd5, 4);
    run("M=N", 16'd13, 16'd13, 16'd5, 4);
    start_op(16'd5, 16'd13, 16'd11, 4);
    check("err cleared in LOAD", 64'(bus.err), 64'd0);
    finish_op("valid after err", 16'd5, 16'd13, 16'd11, 4);

    // Zero length and modulus one.
    run("len0", 16'd7, 16'd11, 16'd5, 0);
    run("len0 N=1", 16'd7, 16'd1, 16'd5, 0);
    run("M0 N1", 16'd0, 16'd1, 16'd5, 3);

    // Abort at cycle 10 of a run.
    start_op(16'd5, 16'd13, 16'd11, 4);
    repeat (9) cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort ready", 64'(bus.ready), 64'd1);
    check("abort S_out", 64'(bus.S_out), 64'd0);
    check("abort err", 64'(bus.err), 64'd0);
    watch_no_done("abort");

    // Reset at cycle 20 of a run, with a stray start pulse before it.
    start_op(16'd5, 16'd13, 16'd11, 4);
    repeat (5) cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (13) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid reset ready", 64'(bus.ready), 64'd1);
    check("mid reset S_out", 64'(bus.S_out), 64'd0);
    check("mid reset err", 64'(bus.err), 64'd0);
    watch_no_done("mid reset");

    // A start pulse with other operands during a run is ignored.
    start_op(16'd4, 16'd497, 16'd13, 4);
    repeat (20) cyc();
    bus.M_i     = 16'd1;
    bus.N_i     = 16'd3;
    bus.d_i     = 16'd1;
    bus.d_len_i = CW'(1);
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
    finish_op("start ignored", 16'd4, 16'd497, 16'd13, 4);

    // Abort while idle is ignored; start together with abort in idle is accepted.
    bus.abort = 1'b1;
    cyc();
    check("idle abort ready", 64'(bus.ready), 64'd1);
    start_op(16'd3, 16'd7, 16'd6, 3);
    bus.abort = 1'b0;
    check("start+abort accepted", 64'(bus.ready), 64'd0);
    finish_op("start+abort run", 16'd3, 16'd7, 16'd6, 3);

    // Randomized back-to-back operations against the model.
    for (int v = 0; v < 40; v++) begin
      rn = 16'($urandom_range(1, 65535));
      if (v % 2 == 1) rn = rn | 16'd1;
      else            rn = rn & 16'hFFFE;
      if (rn == '0) rn = 16'd2;
      rm = 16'($urandom % 32'(rn));
      rd = 16'($urandom);
      rl = (v % 4 == 0) ? 16 : int'($urandom_range(0, 20));
      run($sformatf("rand%0d", v), rm, rn, rd, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
